// File: rtl/fifo_write_feeder_if.sv
// Producer stream and FIFO write-port signals seen by the write feeder.
interface fifo_write_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  full;

    // master is the feeder; slave is the producer plus FIFO side
    modport master (
        input  in_valid, in_data, full,
        output in_ready, data_in, wr_en
    );
    modport slave (
        output in_valid, in_data, full,
        input  in_ready, data_in, wr_en
    );
endinterface

// File: rtl/fifo_write_feeder.sv
// Two-entry skid buffer between a valid/ready producer and an async FIFO write port,
// with a wrapping write counter and a saturating full-stall counter.
module fifo_write_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_write_feeder_if.master  bus,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] stall_count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                  occ_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [CNT_WIDTH-1:0]  wr_count_q;
    logic [CNT_WIDTH-1:0]  stall_count_q;
    logic                  push;
    logic                  pop;
    logic                  stall;

    // in_ready looks only at registered occupancy, so full never reaches the producer combinationally
    assign bus.in_ready = (occ_q != TWO) && !rst;
    assign bus.wr_en    = (occ_q != EMPTY) && !bus.full && !rst;
    assign bus.data_in  = head_q;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.wr_en;
    assign stall        = (occ_q != EMPTY) && bus.full;

    assign wr_count     = wr_count_q;
    assign stall_count  = stall_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q         <= EMPTY;
            head_q        <= '0;
            tail_q        <= '0;
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            unique case (occ_q)
                EMPTY: begin
                    if (push) begin
                        head_q <= bus.in_data;
                        occ_q  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= bus.in_data;
                    end else if (push) begin
                        tail_q <= bus.in_data;
                        occ_q  <= TWO;
                    end else if (pop) begin
                        occ_q  <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q <= tail_q;
                        occ_q  <= ONE;
                    end
                end
                default: occ_q <= EMPTY;
            endcase

            // a clear request outranks any increment in the same cycle
            if (cnt_clr) begin
                wr_count_q    <= '0;
                stall_count_q <= '0;
            end else begin
                if (pop) begin
                    wr_count_q <= wr_count_q + 1'b1;
                end
                if (stall && (stall_count_q != '1)) begin
                    stall_count_q <= stall_count_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_feeder.sv
// Directed and random checks of the write feeder; a wide-counter and a 4-bit-counter
// instance see identical stimulus so wrap and saturation are observed side by side.
module tb_fifo_write_feeder;
    logic        clock = 1'b0;
    logic        rst;
    logic        inValid;
    logic [7:0]  inData;
    logic        full;
    logic        cntClr;
    logic [15:0] wrCountW;
    logic [15:0] stallCountW;
    logic [3:0]  wrCountN;
    logic [3:0]  stallCountN;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [7:0]  sb[$];
    int unsigned mWr     = 0;
    int unsigned mStallW = 0;
    int unsigned mStallN = 0;
    bit          modelKnown = 1'b0;
    int          runLen;

    fifo_write_feeder_if #(.DATA_WIDTH(8)) wideBus ();
    fifo_write_feeder_if #(.DATA_WIDTH(8)) narrowBus ();

    assign wideBus.in_valid   = inValid;
    assign wideBus.in_data    = inData;
    assign wideBus.full       = full;
    assign narrowBus.in_valid = inValid;
    assign narrowBus.in_data  = inData;
    assign narrowBus.full     = full;

    fifo_write_feeder #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dutWide (
        .clk         (clock),
        .rst         (rst),
        .bus         (wideBus),
        .cnt_clr     (cntClr),
        .wr_count    (wrCountW),
        .stall_count (stallCountW)
    );

    fifo_write_feeder #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dutNarrow (
        .clk         (clock),
        .rst         (rst),
        .bus         (narrowBus),
        .cnt_clr     (cntClr),
        .wr_count    (wrCountN),
        .stall_count (stallCountN)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // drive one cycle at the falling edge, check outputs against the model, then advance the model
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                                 input logic f, input logic c);
        logic expReady;
        logic expWrEn;
        logic hadData;
        @(negedge clock);
        rst = r; inValid = v; inData = d; full = f; cntClr = c;
        #1;
        hadData  = (sb.size() != 0);
        expReady = !r && (sb.size() < 2);
        expWrEn  = !r && hadData && !f;
        checkOutput("in_ready_w", 32'(wideBus.in_ready), 32'(expReady));
        checkOutput("in_ready_n", 32'(narrowBus.in_ready), 32'(expReady));
        checkOutput("wr_en_w", 32'(wideBus.wr_en), 32'(expWrEn));
        checkOutput("wr_en_n", 32'(narrowBus.wr_en), 32'(expWrEn));
        if (expWrEn) begin
            checkOutput("data_in_w", 32'(wideBus.data_in), 32'(sb[0]));
            checkOutput("data_in_n", 32'(narrowBus.data_in), 32'(sb[0]));
        end
        if (modelKnown) begin
            checkOutput("wr_count_w", 32'(wrCountW), mWr & 32'hFFFF);
            checkOutput("wr_count_n", 32'(wrCountN), mWr & 32'hF);
            checkOutput("stall_count_w", 32'(stallCountW), mStallW);
            checkOutput("stall_count_n", 32'(stallCountN), mStallN);
        end
        if (r) begin
            sb.delete();
            mWr = 0; mStallW = 0; mStallN = 0;
            modelKnown = 1'b1;
        end else begin
            if (expWrEn) void'(sb.pop_front());
            if (v && expReady) sb.push_back(d);
            if (c) begin
                mWr = 0; mStallW = 0; mStallN = 0;
            end else begin
                if (expWrEn) mWr++;
                if (hadData && f) begin
                    if (mStallW != 32'hFFFF) mStallW++;
                    if (mStallN != 32'hF) mStallN++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; inData = '0; full = 1'b0; cntClr = 1'b0;

        // reset held three cycles with a valid producer
        applyStimulus(1, 1, 8'h55, 0, 0);
        applyStimulus(1, 1, 8'h55, 0, 0);
        checkOutput("rst_data_in", 32'(wideBus.data_in), 32'h0);
        checkOutput("rst_wr_count", 32'(wrCountW), 32'h0);
        checkOutput("rst_stall_count", 32'(stallCountW), 32'h0);
        applyStimulus(1, 1, 8'h55, 0, 0);
        checkOutput("rst_in_ready", 32'(wideBus.in_ready), 32'h0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("release_in_ready", 32'(wideBus.in_ready), 32'h1);
        checkOutput("release_wr_en", 32'(wideBus.wr_en), 32'h0);

        // back-to-back streaming of 0x01..0x10
        runLen = 0;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1, 8'(i), 0, 0);
            if (wideBus.wr_en) runLen++;
            if (i == 2) checkOutput("stream_first_word", 32'(wideBus.data_in), 32'h01);
        end
        applyStimulus(0, 0, 8'h00, 0, 0);
        if (wideBus.wr_en) runLen++;
        checkOutput("stream_last_word", 32'(wideBus.data_in), 32'h10);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("stream_run_len", 32'(runLen), 32'd16);
        checkOutput("stream_wr_count", 32'(wrCountW), 32'd16);

        applyStimulus(0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("clr_wr_count", 32'(wrCountW), 32'd0);

        // five cycles of full in the middle of a stream; producer holds 0x24 while stalled
        applyStimulus(0, 1, 8'h21, 0, 0);
        applyStimulus(0, 1, 8'h22, 0, 0);
        applyStimulus(0, 1, 8'h23, 1, 0);
        checkOutput("bp_wr_en_drop", 32'(wideBus.wr_en), 32'h0);
        checkOutput("bp_absorb_ready", 32'(wideBus.in_ready), 32'h1);
        applyStimulus(0, 1, 8'h24, 1, 0);
        checkOutput("bp_ready_low", 32'(wideBus.in_ready), 32'h0);
        applyStimulus(0, 1, 8'h24, 1, 0);
        applyStimulus(0, 1, 8'h24, 1, 0);
        applyStimulus(0, 1, 8'h24, 1, 0);
        applyStimulus(0, 1, 8'h24, 0, 0);
        checkOutput("bp_resume_word", 32'(wideBus.data_in), 32'h22);
        checkOutput("bp_ready_still_low", 32'(wideBus.in_ready), 32'h0);
        applyStimulus(0, 1, 8'h24, 0, 0);
        applyStimulus(0, 1, 8'h25, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("bp_stall_count", 32'(stallCountW), 32'd5);
        checkOutput("bp_wr_count", 32'(wrCountW), 32'd5);

        // counter wrap and saturation on the 4-bit instance
        applyStimulus(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 8'(8'h40 + i), 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("wrap_wr_count_n", 32'(wrCountN), 32'd4);
        checkOutput("wrap_wr_count_w", 32'(wrCountW), 32'd20);
        applyStimulus(0, 0, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'h77, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("sat_stall_count_n", 32'(stallCountN), 32'd15);
        checkOutput("sat_stall_count_w", 32'(stallCountW), 32'd20);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("clr_write_wr_en", 32'(wideBus.wr_en), 32'h1);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("clr_write_wr_count", 32'(wrCountN), 32'd0);
        checkOutput("clr_write_stall_count", 32'(stallCountN), 32'd0);

        // reset while two words are parked behind full
        applyStimulus(0, 1, 8'hAA, 1, 0);
        applyStimulus(0, 1, 8'hBB, 1, 0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("mid_two_ready", 32'(wideBus.in_ready), 32'h0);
        applyStimulus(1, 0, 8'h00, 0, 0);
        checkOutput("mid_rst_wr_en", 32'(wideBus.wr_en), 32'h0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("mid_after_wr_en", 32'(wideBus.wr_en), 32'h0);
        checkOutput("mid_after_ready", 32'(wideBus.in_ready), 32'h1);
        checkOutput("mid_after_data_in", 32'(wideBus.data_in), 32'h0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("mid_no_write", 32'(wrCountW), 32'd0);

        // random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom_range(0, 1999) == 0),
                          ($urandom_range(0, 9) < 7),
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 499) == 0));
        end
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
